// File: rtl/bcd_pkg.sv
// Shared BCD definitions: FSM states, digit constants and the active-low 7-segment table.
// Segment bit order is bit0 = a through bit6 = g; codes above 9 show blank.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADD3_THRESH = 5;

  localparam logic [6:0] SEG_BLANK = 7'h7f;

  // Index n holds the pattern for digit n; index 10 is blank.
  localparam logic [10:0][6:0] SEG_TABLE = {
    SEG_BLANK, 7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] seg7(input logic [3:0] d);
    return (d <= 4'd9) ? SEG_TABLE[d] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so the next
// left shift carries correctly into the digit above.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  assign dout = (din >= BCD_DIGIT_W'(ADD3_THRESH)) ? din + BCD_DIGIT_W'(3) : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle, start/busy/done.
// Defining BIN_TO_BCD_SEG_EN adds a registered active-low 7-segment output per digit.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          CLOCK_50,
  input  logic                          RESET,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          overflow
`ifdef BIN_TO_BCD_SEG_EN
  ,
  output logic [7*DIGITS-1:0]           seg_out
`endif
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t            state;
  logic [SR_W-1:0]   sr;
  logic [CNT_W-1:0]  cnt;
  logic              ovf_acc;

  logic [BCD_W-1:0]  bcd_adj;
  logic [SR_W-1:0]   sr_adj;
  logic [SR_W-1:0]   sr_shift;
  logic              shift_out;
  logic [BCD_W-1:0]  bcd_final;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (sr[BIN_W + BCD_DIGIT_W*i +: BCD_DIGIT_W]),
      .dout (bcd_adj[BCD_DIGIT_W*i +: BCD_DIGIT_W])
    );
  end

  assign sr_adj    = {bcd_adj, sr[BIN_W-1:0]};
  assign sr_shift  = {sr_adj[SR_W-2:0], 1'b0};
  assign shift_out = sr_adj[SR_W-1];
  assign bcd_final = sr_shift[SR_W-1 -: BCD_W];

`ifdef BIN_TO_BCD_SEG_EN
  logic [7*DIGITS-1:0] seg_next;

  always_comb begin
    seg_next = '1;
    for (int i = 0; i < DIGITS; i++) begin
      seg_next[7*i +: 7] = seg7(bcd_final[BCD_DIGIT_W*i +: BCD_DIGIT_W]);
    end
  end
`endif

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      ovf_acc  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
`ifdef BIN_TO_BCD_SEG_EN
      seg_out  <= '1;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sr      <= {{BCD_W{1'b0}}, bin_in};
            cnt     <= CNT_W'(BIN_W);
            ovf_acc <= 1'b0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          sr      <= sr_shift;
          cnt     <= cnt - 1'b1;
          ovf_acc <= ovf_acc | shift_out;
          // Result is taken from the last shift directly so outputs never show partials.
          if (cnt == CNT_W'(1)) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            bcd_out  <= bcd_final;
            overflow <= ovf_acc | shift_out;
`ifdef BIN_TO_BCD_SEG_EN
            seg_out  <= seg_next;
`endif
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomized scoreboard bench for bin_to_bcd_seq: stimulus queues expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_bin_to_bcd_seq;

  localparam int BIN_W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  bin_in = '0;
  logic        busy, done, overflow;
  logic [11:0] bcd_out;

  logic        start2 = 1'b0;
  logic [7:0]  bin2 = '0;
  logic        busy2, done2, overflow2;
  logic [7:0]  bcd2;

`ifdef BIN_TO_BCD_SEG_EN
  logic [20:0] seg_out;
  logic [13:0] seg2;
`endif

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .CLOCK_50(clk), .RESET(rst), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
`ifdef BIN_TO_BCD_SEG_EN
    , .seg_out(seg_out)
`endif
  );

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
    .CLOCK_50(clk), .RESET(rst), .start(start2), .bin_in(bin2),
    .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(overflow2)
`ifdef BIN_TO_BCD_SEG_EN
    , .seg_out(seg2)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          val;
    logic [11:0] bcd;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Decimal digits by plain division; digits beyond the field are dropped.
  function automatic exp_t model(input int v, input int digits);
    exp_t e;
    int   p = v;
    int   lim = 1;
    e.val = v;
    e.bcd = '0;
    for (int i = 0; i < digits; i++) begin
      e.bcd[4*i +: 4] = 4'(p % 10);
      p = p / 10;
      lim = lim * 10;
    end
    e.ovf = (v >= lim);
    e.due = 0;
    return e;
  endfunction

`ifdef BIN_TO_BCD_SEG_EN
  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction
`endif

  // Monitor: every done pulse must match the oldest queued expectation.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_done <= 1'b0;
    end else begin
      if (prev_done && done) check("done_single_cycle", 1, 0);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check($sformatf("bcd_out[%0d]", e.val), int'(bcd_out), int'(e.bcd));
          check($sformatf("overflow[%0d]", e.val), int'(overflow), int'(e.ovf));
          check($sformatf("done_latency[%0d]", e.val), cyc, e.due);
          check("busy_low_in_done", int'(busy), 0);
          for (int i = 0; i < 3; i++)
            if (bcd_out[4*i +: 4] > 4'd9) check("digit_range", int'(bcd_out[4*i +: 4]), 9);
`ifdef BIN_TO_BCD_SEG_EN
          for (int i = 0; i < 3; i++)
            check($sformatf("seg_out_d%0d[%0d]", i, e.val), int'(seg_out[7*i +: 7]),
                  int'(ref_seg(int'(e.bcd[4*i +: 4]))));
`endif
        end
      end
      prev_done <= done;
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || done) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("idle_timeout", 1, 0);
  endtask

  // Issues a start known to be accepted and queues its expected result.
  task automatic convert(input int v);
    exp_t e;
    wait_idle();
    e = model(v, 3);
    e.due = cyc + 1 + BIN_W;
    exp_q.push_back(e);
    start  = 1'b1;
    bin_in = 8'(v);
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic convert2(input int v);
    exp_t e;
    int   n = 0;
    e = model(v, 2);
    @(negedge clk);
    start2 = 1'b1;
    bin2   = 8'(v);
    @(negedge clk);
    start2 = 1'b0;
    while (!done2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("dut2_timeout", 1, 0);
    else begin
      check($sformatf("dut2_bcd[%0d]", v), int'(bcd2), int'(e.bcd[7:0]));
      check($sformatf("dut2_overflow[%0d]", v), int'(overflow2), int'(e.ovf));
`ifdef BIN_TO_BCD_SEG_EN
      for (int i = 0; i < 2; i++)
        check($sformatf("dut2_seg_d%0d[%0d]", i, v), int'(seg2[7*i +: 7]),
              int'(ref_seg(int'(e.bcd[4*i +: 4]))));
`endif
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_bcd_out"}, int'(bcd_out), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
`ifdef BIN_TO_BCD_SEG_EN
    check({tag, "_seg_out"}, int'(seg_out), 21'h1fffff);
`endif
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    convert(19);
    convert(0);
    convert(255);

    // Restart attempts and input changes while busy must not disturb the result.
    convert(99);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      start  = 1'b1;
      bin_in = 8'd7;
      @(negedge clk);
    end
    start = 1'b0;

    // Reset mid-conversion aborts with no done pulse.
    convert(200);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("abort");
    repeat (12) @(negedge clk);
    check("abort_no_done", int'(done), 0);
    convert(42);

    // Reset and start together: start is dropped.
    wait_idle();
    rst    = 1'b1;
    start  = 1'b1;
    bin_in = 8'd77;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check_reset_outputs("rst_start");
    repeat (12) @(negedge clk);

    convert2(150);
    convert2(19);
    convert2(99);
    convert2(100);
    convert2(255);

    for (int k = 0; k < 40; k++) begin
      convert(int'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 4)) @(negedge clk);
      bin_in = 8'($urandom);
      if (busy && ($urandom_range(0, 1) == 1)) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("pending_results", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
